// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: phase encoding, schedule step boundaries and the step-to-lamp map
package traffic_light_pkg;
    localparam logic [1:0] PH_GREEN  = 2'd0;
    localparam logic [1:0] PH_DARK   = 2'd1;
    localparam logic [1:0] PH_YELLOW = 2'd2;
    localparam logic [1:0] PH_RED    = 2'd3;
    localparam logic [4:0] STEP_PASS  = 5'd7;
    localparam logic [4:0] STEP_DARK0 = 5'd8;
    localparam logic [4:0] STEP_DARK1 = 5'd10;
    localparam logic [4:0] STEP_YEL   = 5'd12;
    localparam logic [4:0] STEP_RED   = 5'd16;
    localparam logic [4:0] STEP_LAST  = 5'd23;

    function automatic logic [1:0] step_phase(input logic [4:0] s);
        return s >= STEP_RED ? PH_RED :
               s >= STEP_YEL ? PH_YELLOW :
               (s == STEP_DARK0 || s == STEP_DARK1) ? PH_DARK : PH_GREEN;
    endfunction

    // lamp triple is {R,G,Y}
    function automatic logic [2:0] step_lamps(input logic [4:0] s);
        logic [1:0] ph;
        ph = step_phase(s);
        return ph == PH_RED ? 3'b100 : ph == PH_YELLOW ? 3'b001 : ph == PH_DARK ? 3'b000 : 3'b010;
    endfunction
endpackage

// File: rtl/traffic_light_shadow.sv
// traffic_light_shadow: free-running step/unit counters mirroring the controller schedule
module traffic_light_shadow import traffic_light_pkg::*; #(
    parameter int UNIT  = 64,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pass,
    output logic [4:0] step,
    output logic [1:0] phase,
    output logic       wrap
);
    logic [CNT_W-1:0] unit, unit_nx;
    logic [4:0] step_nx;
    logic wrap_nx, last_unit;

    assign last_unit = unit == CNT_W'(UNIT - 1);
    assign phase = step_phase(step);

    // pass only restarts once the green minimum is served; earlier it just burns units
    always_comb begin
        unit_nx = last_unit ? '0 : unit + 1'b1;
        step_nx = step;
        wrap_nx = 1'b0;
        if (pass && step >= STEP_PASS) begin
            unit_nx = '0;
            step_nx = '0;
        end else if (!pass && last_unit) begin
            step_nx = step == STEP_LAST ? 5'd0 : step + 5'd1;
            wrap_nx = step == STEP_LAST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit <= '0;
            step <= '0;
            wrap <= 1'b0;
        end else begin
            unit <= unit_nx;
            step <= step_nx;
            wrap <= wrap_nx;
        end
    end
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive lamp checker comparing controller lamps against a shadow schedule
module traffic_light_monitor import traffic_light_pkg::*; #(
    parameter int UNIT  = 64,
    parameter int CNT_W = 6,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pass,
    input  logic             R,
    input  logic             G,
    input  logic             Y,
    output logic [4:0]       step,
    output logic [1:0]       phase,
    output logic             err,
    output logic             err_illegal,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [4:0]       first_err_step,
    output logic             cycle_done
);
    logic mis, ill;

    traffic_light_shadow #(.UNIT(UNIT), .CNT_W(CNT_W)) u_shadow (
        .clk(clk), .rst(rst), .pass(pass), .step(step), .phase(phase), .wrap(cycle_done)
    );

    // the shadow step already reflects the edge that produced these lamps
    assign mis = {R, G, Y} != step_lamps(step);
    assign ill = (R & G) | (R & Y) | (G & Y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err             <= 1'b0;
            err_illegal     <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_step  <= '0;
        end else begin
            err         <= mis;
            err_illegal <= ill;
            if (mis && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
            if (mis && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_step  <= step;
            end
        end
    end
endmodule
